// File: rtl/bm_scheduler.sv
// bm_scheduler: sequencer for the Viterbi branch-metric datapath.
// Latches one received 2-bit symbol, then walks all 2^K trellis branches
// through a single shared external Xor_2bit, converting each XOR result to
// a Hamming metric and streaming {state, bit, metric} over valid/ready.
// Optional build macro: ERASURE_EN adds sym_erase[1:0] to mask code bits.
module bm_scheduler #(
    parameter int unsigned    K     = 3,
    parameter logic [K-1:0]   G0    = 3'b111,
    parameter logic [K-1:0]   G1    = 3'b101,
    parameter int unsigned    CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [1:0]       sym,
`ifdef ERASURE_EN
    input  logic [1:0]       sym_erase,
`endif
    output logic [1:0]       xor_in1,
    output logic [1:0]       xor_in2,
    input  logic [1:0]       xor_out,
    output logic             bm_valid,
    input  logic             bm_ready,
    output logic [K-2:0]     bm_state,
    output logic             bm_bit,
    output logic [1:0]       bm_metric,
    output logic             bm_last,
    output logic [CNT_W-1:0] sym_cnt
);

    localparam int unsigned SW = K - 1;

    localparam logic [K-1:0]     IDX_ONE  = K'(1);
    localparam logic [K-1:0]     IDX_LAST = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT
    } state_t;

    state_t           state_q, state_d;
    logic [K-1:0]     idx_q, idx_d;
    logic [1:0]       sym_q, sym_d;
    logic             valid_q, valid_d;
    logic [SW-1:0]    bstate_q, bstate_d;
    logic             bbit_q, bbit_d;
    logic [1:0]       metric_q, metric_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef ERASURE_EN
    logic [1:0]       erase_q, erase_d;
`endif

    logic [K-1:0]     idx_next;
    logic [K-1:0]     drive_idx;
    logic [1:0]       keep_mask;
    logic [1:0]       masked;
    logic [1:0]       metric_now;

    // Expected code word for branch index {state, bit}; register is {bit, state}.
    function automatic logic [1:0] exp_word(input logic [K-1:0] ix);
        logic [K-1:0] r;
        r = {ix[0], ix[K-1:1]};
        return {^(r & G0), ^(r & G1)};
    endfunction

    assign idx_next = idx_q + IDX_ONE;

    // While a beat is presented the XOR already evaluates the following
    // branch, so an accepted beat can be replaced on the very same edge.
    always_comb begin
        drive_idx = (state_q == ST_EMIT) ? idx_next : idx_q;
    end

    // Erased code-bit positions contribute nothing to the metric.
    always_comb begin
`ifdef ERASURE_EN
        keep_mask = ~erase_q;
`else
        keep_mask = '1;
`endif
        masked     = xor_out & keep_mask;
        metric_now = {1'b0, masked[1]} + {1'b0, masked[0]};
    end

    // Next-state and datapath-register update for the branch walk.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sym_d    = sym_q;
        valid_d  = valid_q;
        bstate_d = bstate_q;
        bbit_d   = bbit_q;
        metric_d = metric_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
`ifdef ERASURE_EN
        erase_d  = erase_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (sym_valid) begin
                    sym_d   = sym;
`ifdef ERASURE_EN
                    erase_d = sym_erase;
`endif
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                metric_d = metric_now;
                bstate_d = idx_q[SW:1];
                bbit_d   = idx_q[0];
                last_d   = (idx_q == IDX_LAST);
                valid_d  = 1'b1;
                state_d  = ST_EMIT;
            end
            ST_EMIT: begin
                if (bm_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d    = idx_next;
                        metric_d = metric_now;
                        bstate_d = idx_next[SW:1];
                        bbit_d   = idx_next[0];
                        last_d   = (idx_next == IDX_LAST);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            sym_q    <= '0;
            valid_q  <= 1'b0;
            bstate_q <= '0;
            bbit_q   <= 1'b0;
            metric_q <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef ERASURE_EN
            erase_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sym_q    <= sym_d;
            valid_q  <= valid_d;
            bstate_q <= bstate_d;
            bbit_q   <= bbit_d;
            metric_q <= metric_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
`ifdef ERASURE_EN
            erase_q  <= erase_d;
`endif
        end
    end

    assign sym_ready = (state_q == ST_IDLE);
    assign xor_in1   = sym_q;
    assign xor_in2   = exp_word(drive_idx);
    assign bm_valid  = valid_q;
    assign bm_state  = bstate_q;
    assign bm_bit    = bbit_q;
    assign bm_metric = metric_q;
    assign bm_last   = last_q;
    assign sym_cnt   = cnt_q;

endmodule
